// File: rtl/canny_in_block.sv
// SRAM read/unpack front end for the Canny pipeline: fetches row-A/row-B word pairs
// and streams them out as two pixels per row per clock, double-buffered against the reads.
module canny_in_block #(
  parameter int unsigned STARTADDRESS = 0,
  parameter int unsigned ENDADDRESS   = 524288,
  parameter int unsigned RDLATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] inData,
  output logic        re,
  output logic [19:0] rdaddr,
  output logic [7:0]  pixByte1,
  output logic [7:0]  pixByte2,
  output logic [7:0]  pixByte3,
  output logic [7:0]  pixByte4,
  output logic        pixValid,
  output logic        busy,
  output logic        done
);

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 64;
  localparam logic [AW-1:0] START_ADDR = AW'(STARTADDRESS);
  localparam logic [AW:0]   END_ADDR   = (AW+1)'(ENDADDRESS);
  localparam logic [AW-1:0] ROW_B_OFS  = AW'(256);
  localparam logic [1:0]    CAP_A_PH   = 2'(RDLATENCY);
  localparam logic [1:0]    CAP_B_PH   = 2'(RDLATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_STREAM, S_DRAIN} state_t;

  state_t        r_state;
  logic [1:0]    r_phase;
  logic [AW-1:0] r_cur;
  logic          r_last;
  logic [DW-1:0] r_ld_a, r_ld_b, r_out_a, r_out_b;
  logic          r_re;
  logic [AW-1:0] r_rdaddr;
  logic [7:0]    r_pix1, r_pix2, r_pix3, r_pix4;
  logic          r_pix_valid, r_busy, r_done;

  logic          w_reading;
  logic [AW:0]   w_next;
  logic          w_last;
  logic [DW-1:0] w_b_word;
  logic [15:0]   w_a0, w_b0, w_a_nx, w_b_nx;

  function automatic logic [15:0] f_half(input logic [DW-1:0] w, input logic [1:0] k);
    logic [15:0] h;
    case (k)
      2'd0:    h = w[63:48];
      2'd1:    h = w[47:32];
      2'd2:    h = w[31:16];
      default: h = w[15:0];
    endcase
    return h;
  endfunction

  assign w_reading = (r_state == S_PREFILL) || (r_state == S_STREAM);
  // End of a row-A block jumps over the interleaved row-B block.
  assign w_next    = {1'b0, r_cur} + ((r_cur[7:0] == 8'hFF) ? (AW+1)'(257) : (AW+1)'(1));
  assign w_last    = (w_next >= END_ADDR);
  // With two-cycle latency the row-B word lands on the transfer edge itself.
  assign w_b_word  = (RDLATENCY == 2) ? inData : r_ld_b;
  assign w_a0      = f_half(r_ld_a, 2'd0);
  assign w_b0      = f_half(w_b_word, 2'd0);
  assign w_a_nx    = f_half(r_out_a, r_phase + 2'd1);
  assign w_b_nx    = f_half(r_out_b, r_phase + 2'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phase     <= 2'd0;
      r_cur       <= START_ADDR;
      r_last      <= 1'b0;
      r_ld_a      <= '0;
      r_ld_b      <= '0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_re        <= 1'b0;
      r_rdaddr    <= '0;
      r_pix1      <= '0;
      r_pix2      <= '0;
      r_pix3      <= '0;
      r_pix4      <= '0;
      r_pix_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_phase <= 2'd0;
        if (start) begin
          r_state  <= S_PREFILL;
          r_busy   <= 1'b1;
          r_re     <= 1'b1;
          r_rdaddr <= START_ADDR;
          r_cur    <= START_ADDR;
          r_last   <= 1'b0;
        end
      end else begin
        r_phase <= r_phase + 2'd1;
        if (w_reading) begin
          if (r_phase == CAP_A_PH) r_ld_a <= inData;
          if (r_phase == CAP_B_PH) r_ld_b <= inData;
        end
        // Emit the remaining three halves of the output buffer.
        if (r_state != S_PREFILL && r_phase != 2'd3) begin
          r_pix3 <= w_a_nx[15:8];
          r_pix4 <= w_a_nx[7:0];
          r_pix1 <= w_b_nx[15:8];
          r_pix2 <= w_b_nx[7:0];
        end
        case (r_phase)
          2'd0: begin
            r_re <= w_reading;
            if (w_reading) r_rdaddr <= r_cur + ROW_B_OFS;
          end
          2'd1: begin
            r_re <= 1'b0;
            if (w_reading) begin
              r_cur  <= AW'(w_next);
              r_last <= w_last;
            end
          end
          2'd2: r_re <= 1'b0;
          default: begin
            if (w_reading) begin
              r_out_a     <= r_ld_a;
              r_out_b     <= w_b_word;
              r_pix3      <= w_a0[15:8];
              r_pix4      <= w_a0[7:0];
              r_pix1      <= w_b0[15:8];
              r_pix2      <= w_b0[7:0];
              r_pix_valid <= 1'b1;
              if (r_last) begin
                r_state <= S_DRAIN;
                r_re    <= 1'b0;
              end else begin
                r_state  <= S_STREAM;
                r_re     <= 1'b1;
                r_rdaddr <= r_cur;
              end
            end else begin
              r_state     <= S_IDLE;
              r_pix_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign re       = r_re;
  assign rdaddr   = r_rdaddr;
  assign pixByte1 = r_pix1;
  assign pixByte2 = r_pix2;
  assign pixByte3 = r_pix3;
  assign pixByte4 = r_pix4;
  assign pixValid = r_pix_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_canny_in_block.sv
// Directed bench for canny_in_block: three instances (END 512 / lat 1, END 512 / lat 2,
// END 1024 / lat 1), each fed by its own SRAM model, checked cycle by cycle.
module tb_canny_in_block;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0]        start_v = '0;
  logic [2:0]        re_v, valid_v, busy_v, done_v;
  logic [2:0][19:0]  addr_v;
  logic [2:0][63:0]  data_v, s1, s2;
  logic [2:0][7:0]   p1_v, p2_v, p3_v, p4_v;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  canny_in_block #(.STARTADDRESS(0), .ENDADDRESS(512), .RDLATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .inData(data_v[0]), .re(re_v[0]),
    .rdaddr(addr_v[0]), .pixByte1(p1_v[0]), .pixByte2(p2_v[0]), .pixByte3(p3_v[0]),
    .pixByte4(p4_v[0]), .pixValid(valid_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  canny_in_block #(.STARTADDRESS(0), .ENDADDRESS(512), .RDLATENCY(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .inData(data_v[1]), .re(re_v[1]),
    .rdaddr(addr_v[1]), .pixByte1(p1_v[1]), .pixByte2(p2_v[1]), .pixByte3(p3_v[1]),
    .pixByte4(p4_v[1]), .pixValid(valid_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  canny_in_block #(.STARTADDRESS(0), .ENDADDRESS(1024), .RDLATENCY(1)) u_dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .inData(data_v[2]), .re(re_v[2]),
    .rdaddr(addr_v[2]), .pixByte1(p1_v[2]), .pixByte2(p2_v[2]), .pixByte3(p3_v[2]),
    .pixByte4(p4_v[2]), .pixValid(valid_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  function automatic logic [63:0] mem(input logic [19:0] a);
    if (a == 20'd0)   return 64'h0102030405060708;
    if (a == 20'd256) return 64'h1112131415161718;
    return {4{a[15:0]}};
  endfunction

  function automatic logic [19:0] f_addr_a(input int p);
    return 20'((p / 256) * 512 + (p % 256));
  endfunction

  function automatic logic [15:0] f_half(input logic [63:0] w, input int k);
    logic [63:0] t;
    t = w >> (48 - 16 * k);
    return t[15:0];
  endfunction

  // Read data is garbage except in the slots that follow a real read.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++)
      s1[d] <= re_v[d] ? mem(addr_v[d]) : 64'hDEADBEEFDEADBEEF;
    s2 <= s1;
  end
  assign data_v[0] = s1[0];
  assign data_v[1] = s2[1];
  assign data_v[2] = s1[2];

  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_vec++;
      if ({re_v[d], addr_v[d], p1_v[d], p2_v[d], p3_v[d], p4_v[d], valid_v[d], busy_v[d], done_v[d]} !== '0) begin
        n_err++;
        $display("FAIL reset_state dut%0d: re=%b addr=%h valid=%b busy=%b done=%b expected all zero",
                 d, re_v[d], addr_v[d], valid_v[d], busy_v[d], done_v[d]);
      end
    end
    reset = 1'b0;
  endtask

  // Runs one frame on instance d and checks every output on every cycle.
  task automatic test_frame(input int d, input int npairs, input bit pulse, input bit mid_start, input bit chain);
    int last_n, n_re, n_val, n_done, p, k, v;
    logic exp_re, exp_val, exp_busy, exp_done;
    logic [19:0] exp_addr;
    logic [31:0] exp_pix, obs_pix;
    logic [31:0] first_tab [4];
    first_tab[0] = 32'h01021112;
    first_tab[1] = 32'h03041314;
    first_tab[2] = 32'h05061516;
    first_tab[3] = 32'h07081718;
    n_re = 0; n_val = 0; n_done = 0;
    if (pulse) start_v[d] = 1'b1;
    @(posedge clk);
    #1 start_v[d] = 1'b0;
    last_n = chain ? 4 * npairs + 5 : 4 * npairs + 6;
    for (int n = 1; n <= last_n; n++) begin
      @(negedge clk);
      p = (n - 1) / 4;
      k = (n - 1) % 4;
      exp_re   = (p < npairs) && (k < 2);
      exp_addr = f_addr_a(p) + ((k == 1) ? 20'd256 : 20'd0);
      exp_val  = (n >= 5) && (n <= 4 * npairs + 4);
      exp_busy = (n <= 4 * npairs + 4);
      exp_done = (n == 4 * npairs + 5);
      n_vec++;
      if (re_v[d] !== exp_re) begin
        n_err++;
        $display("FAIL re dut%0d cycle %0d: got %b expected %b", d, n, re_v[d], exp_re);
      end
      if (exp_re) begin
        n_vec++;
        if (addr_v[d] !== exp_addr) begin
          n_err++;
          $display("FAIL rdaddr dut%0d cycle %0d: got %0d expected %0d", d, n, addr_v[d], exp_addr);
        end
      end
      n_vec++;
      if ({valid_v[d], busy_v[d], done_v[d]} !== {exp_val, exp_busy, exp_done}) begin
        n_err++;
        $display("FAIL valid_busy_done dut%0d cycle %0d: got %b%b%b expected %b%b%b",
                 d, n, valid_v[d], busy_v[d], done_v[d], exp_val, exp_busy, exp_done);
      end
      if (exp_val) begin
        v = n - 5;
        if (v < 4) exp_pix = first_tab[v];
        else exp_pix = {f_half(mem(f_addr_a(v / 4)), v % 4), f_half(mem(f_addr_a(v / 4) + 20'd256), v % 4)};
        obs_pix = {p3_v[d], p4_v[d], p1_v[d], p2_v[d]};
        n_vec++;
        if (obs_pix !== exp_pix) begin
          n_err++;
          $display("FAIL pixels dut%0d valid#%0d: got p3p4p1p2=%h expected %h", d, v, obs_pix, exp_pix);
        end
      end
      if (re_v[d] === 1'b1) n_re++;
      if (valid_v[d] === 1'b1) n_val++;
      if (done_v[d] === 1'b1) n_done++;
      if (mid_start) start_v[d] = (n == 10);
      if (chain && n == 4 * npairs + 4) start_v[d] = 1'b1;
    end
    n_vec++;
    if (n_re !== 2 * npairs || n_val !== 4 * npairs || n_done !== 1) begin
      n_err++;
      $display("FAIL frame_counts dut%0d: reads=%0d valid=%0d done=%0d expected %0d/%0d/1",
               d, n_re, n_val, n_done, 2 * npairs, 4 * npairs);
    end
  endtask

  task automatic test_reset_mid;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (40) @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++;
    if ({re_v[0], valid_v[0], busy_v[0], done_v[0]} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_mid_immediate: re/valid/busy/done=%b%b%b%b expected 0000",
               re_v[0], valid_v[0], busy_v[0], done_v[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      n_vec++;
      if ({re_v[0], busy_v[0], done_v[0]} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_mid_quiet cycle %0d: re/busy/done=%b%b%b expected 000",
                 n, re_v[0], busy_v[0], done_v[0]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_frame(0, 256, 1'b1, 1'b1, 1'b0);
    test_frame(1, 256, 1'b1, 1'b0, 1'b1);
    test_frame(1, 256, 1'b0, 1'b0, 1'b0);
    test_frame(2, 512, 1'b1, 1'b0, 1'b0);
    test_reset_mid;
    test_frame(0, 256, 1'b1, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
